// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-side result bundle of the UART receiver
interface uart_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_error_o;
  logic       rx_busy_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    output rx_error_o,
    output rx_busy_o
  );

  modport slave (
    input rx_data_o,
    input rx_valid_o,
    input rx_error_o,
    input rx_busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_i,
  uart_rx_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic             sync1_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit of slack for a back-to-back start.
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign bus.rx_data_o  = data_q;
  assign bus.rx_valid_o = valid_q;
  assign bus.rx_error_o = error_q;
  assign bus.rx_busy_o  = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data_o  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid_o  output  1  one-cycle pulse, rx_data_o updated this cycle.
REQ-008 SHALL have port rx_error_o  output  1  one-cycle pulse, framing error (stop bit low).
REQ-009 SHALL have port rx_busy_o  output  1  high while a frame is in progress.

Function
REQ-010 SHALL derive CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer); CLKS_PER_BIT < 4 is unsupported.
REQ-011 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); the FSM samples only the synchronized signal rx_s.
REQ-012 SHALL accept frame format 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE; unreachable encodings return to IDLE.
REQ-014 IDLE: on rx_s==0 -> START, bit-clock counter = 0, rx_busy_o = 1.
REQ-015 START: when counter == CLKS_PER_BIT/2 - 1, rx_s==0 -> DATA (counter = 0, bit index = 0); rx_s==1 -> IDLE, rx_busy_o = 0 (glitch rejected, no pulse).
REQ-016 DATA: when counter == CLKS_PER_BIT - 1, sample rx_s into shift register (right-shift, new bit enters bit 7), counter = 0, bit index +1; after 8th sample -> STOP.
REQ-017 STOP: when counter == CLKS_PER_BIT - 1, rx_s==1 -> rx_data_o = shift register, rx_valid_o = 1 for exactly one cycle, -> IDLE, rx_busy_o = 0.
REQ-018 STOP: when counter == CLKS_PER_BIT - 1, rx_s==0 -> rx_error_o = 1 for one cycle, rx_data_o unchanged, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rx_s==1, then -> IDLE, rx_busy_o = 0; a held-low line (break) produces no further pulses.
REQ-020 Counter SHALL be wide enough to hold CLKS_PER_BIT - 1 without wrap; counter increments every cycle outside IDLE/WAIT_IDLE.
REQ-021 Return to IDLE at mid-stop-bit SHALL allow a back-to-back frame whose start bit begins immediately after the stop bit.
REQ-022 rx_valid_o and rx_error_o SHALL never be high in the same cycle and SHALL self-clear next cycle without acknowledgement.
REQ-023 Latency: rx_valid_o asserts 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1) after the falling start edge on rx_i.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, rx_data_o 0x00, rx_valid_o 0, rx_error_o 0, rx_busy_o 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release, the next falling edge on rx_s starts a new frame.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CLKS_PER_BIT=10)
REQ-026 Send 0xA5 with valid stop -> rx_valid_o one-cycle pulse, rx_data_o=0xA5, rx_error_o stays 0, rx_busy_o low after pulse.
REQ-027 rx_i low for 3 cycles then high -> no valid/error pulse, rx_busy_o returns 0 within 8 cycles, rx_data_o unchanged.
REQ-028 Send 0x3C with stop bit 0, line held low 30 cycles then high -> one rx_error_o pulse, no rx_valid_o, rx_data_o keeps prior value, rx_busy_o high until line returns high.
REQ-029 Back-to-back 0x00 then 0xFF with single stop bits, no idle gap -> two rx_valid_o pulses, data 0x00 then 0xFF, no error.
REQ-030 Assert rst_n low during data bit 4 of 0x5A -> all outputs 0 immediately (before next clk edge); after release and idle line, send 0xC3 -> rx_data_o=0xC3 with single valid pulse.
